rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
Parametrised register file for the pipelined core, replacing the single-write, no-reset register file. It provides two combinational read ports and two synchronous write ports, with write-port priority, a hard-wired zero register and optional write-to-read bypass. A per-register busy scoreboard lets decode stall on pending writes.

Parameters:
DATA_W, 32, width of each register.
ADDR_W, 5, address width; depth NUM_REGS = 2**ADDR_W.
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and ignores reserves.
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
rs_addr  in  ADDR_W  read port A address.
rt_addr  in  ADDR_W  read port B address.
rs_data  out  DATA_W  read port A data (combinational).
rt_data  out  DATA_W  read port B data (combinational).
rs_busy  out  1  busy bit of rs_addr (combinational).
rt_busy  out  1  busy bit of rt_addr (combinational).
wr_en0  in  1  write port 0 enable.
wr_addr0  in  ADDR_W  write port 0 address.
wr_data0  in  DATA_W  write port 0 data.
wr_en1  in  1  write port 1 enable; has priority over port 0.
wr_addr1  in  ADDR_W  write port 1 address.
wr_data1  in  DATA_W  write port 1 data.
rsv_en  in  1  mark rsv_addr pending (sets busy).
rsv_addr  in  ADDR_W  register to reserve.
flush  in  1  synchronous clear of all busy bits.

Behaviour:
- Reset: rst_n low clears all registers and busy bits to 0 immediately, without waiting for a clock edge. While rst_n is low, bypass is suppressed, so rs_data, rt_data, rs_busy and rt_busy read 0. Writes, reserves and flush are ignored during reset.
- Write:
  - At the clock edge, each enabled port writes its data to its address.
  - If both ports target the same address, port 1's data is stored.
  - When ZERO_REG=1, a write to address 0 is dropped.
- Read:
  - rs_data = R[rs_addr], with zero latency.
  - When BYPASS=1 and rs_addr matches an active write, rs_data is that write's data, with port 1 taking precedence on a double match.
  - A bypass to address 0 is blocked when ZERO_REG=1.
  - rt_data follows the same rules.
  - When BYPASS=0, a same-cycle write becomes visible only after the clock edge.
- Scoreboard:
  - A busy bit clears at the edge on which its register is written, by either port.
  - rsv_en sets busy[rsv_addr] at the edge.
  - If a reserve and a write hit the same address in one cycle, the reserve wins and busy stays 1 (new pending producer).
  - flush clears all busy bits and overrides rsv_en in the same cycle. Writes still occur during flush.
  - When ZERO_REG=1, busy[0] is constant 0.
- rs_busy and rt_busy reflect the stored busy bits. There is no bypass on busy: a write in the current cycle does not clear the reported busy bit until after the edge.
- X or out-of-range conditions cannot occur, since depth equals 2**ADDR_W.
- All state is flops; there is no memory macro inference requirement.

Test Plan:
1. Reset mid-operation: write 0xDEADBEEF to R5, then pulse rst_n low between edges → rs_data (rs_addr=5) reads 0 immediately and stays 0 after release.
2. Dual-write collision: wr0 R7=0x11, wr1 R7=0x22 in the same cycle → R7 reads 0x22 next cycle. wr0 R3=0x33 alongside wr1 R4=0x44 → both stored.
3. Bypass: BYPASS=1, wr1 R9=0xA5A5A5A5 with rs_addr=rt_addr=9 in the same cycle → both read ports show 0xA5A5A5A5 before the edge. With BYPASS=0 they show the old value until the edge.
4. Zero register: wr0 R0=0xFFFFFFFF plus rsv R0 → rs_data(0)=0 both before and after the edge, and rs_busy=0.
5. Scoreboard:
   - rsv R12 → rt_busy=1 next cycle.
   - wr0 R12 → rt_busy=0 after the edge.
   - rsv R12 together with wr1 R12 → busy remains 1.
   - rsv R12 together with flush → busy=0.
6. Randomised writes/reads over 1000 cycles against a reference model with port-1 priority → zero mismatches, run under both BYPASS settings.

Source files
------------

// File: rtl/rf_multiport.sv
// Purpose: 2-read / 2-write register file with per-register busy scoreboard and optional write-to-read bypass.
// Latency: reads and busy lookups are combinational; writes, reserves and flush take effect at the rising edge.
// Backpressure: none; every enabled write/reserve/flush is accepted each cycle (stalls are decode's job via busy).
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Effective write enables: writes to the hard-wired zero register are dropped here,
    // which also blocks them from the bypass path and from clearing busy[0].
    logic we0;
    logic we1;
    assign we0 = wr_en0 && !((ZERO_REG != 0) && (wr_addr0 == '0));
    assign we1 = wr_en1 && !((ZERO_REG != 0) && (wr_addr1 == '0));

    // Register array update; port 1 wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we1 && (wr_addr1 == ADDR_W'(i))) begin
                    regs[i] <= wr_data1;
                end else if (we0 && (wr_addr0 == ADDR_W'(i))) begin
                    regs[i] <= wr_data0;
                end
            end
        end
    end

    // Busy scoreboard: flush beats reserve, reserve beats a completing write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((ZERO_REG != 0) && (i == 0)) begin
                    busy[i] <= 1'b0;
                end else if (flush) begin
                    busy[i] <= 1'b0;
                end else if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if ((we0 && (wr_addr0 == ADDR_W'(i))) ||
                             (we1 && (wr_addr1 == ADDR_W'(i)))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read port A: bypass from the current-cycle write (port 1 first), else stored value.
    always_comb begin
        rs_data = regs[rs_addr];
        if (!rst_n) begin
            rs_data = '0;
        end else if ((BYPASS != 0) && we1 && (wr_addr1 == rs_addr)) begin
            rs_data = wr_data1;
        end else if ((BYPASS != 0) && we0 && (wr_addr0 == rs_addr)) begin
            rs_data = wr_data0;
        end
    end

    // Read port B: same forwarding rules as port A.
    always_comb begin
        rt_data = regs[rt_addr];
        if (!rst_n) begin
            rt_data = '0;
        end else if ((BYPASS != 0) && we1 && (wr_addr1 == rt_addr)) begin
            rt_data = wr_data1;
        end else if ((BYPASS != 0) && we0 && (wr_addr0 == rt_addr)) begin
            rt_data = wr_data0;
        end
    end

    // Busy lookups come straight from the stored bits; no forwarding of same-cycle writes.
    always_comb begin
        rs_busy = rst_n && busy[rs_addr];
        rt_busy = rst_n && busy[rt_addr];
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a BYPASS=1 and a BYPASS=0 instance share all inputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
// Directed scenarios first, then a model-checked pseudo-random run.
module tb_rf_multiport;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr;
    logic        wr_en0, wr_en1, rsv_en, flush;
    logic [4:0]  wr_addr0, wr_addr1, rsv_addr;
    logic [31:0] wr_data0, wr_data1;

    logic [31:0] rs_data_b, rt_data_b, rs_data_n, rt_data_n;
    logic        rs_busy_b, rt_busy_b, rs_busy_n, rt_busy_n;

    int checks = 0;
    int errors = 0;

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_b), .rt_data(rt_data_b), .rs_busy(rs_busy_b), .rt_busy(rt_busy_b),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_n), .rt_data(rt_data_n), .rs_busy(rs_busy_n), .rt_busy(rt_busy_n),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wr_en0 = 0; wr_en1 = 0; rsv_en = 0; flush = 0;
        wr_addr0 = 0; wr_addr1 = 0; rsv_addr = 0;
        wr_data0 = 0; wr_data1 = 0;
    endtask

    // Advance through one rising edge; returns 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); rs_addr = 5; rt_addr = 5;
        #2;
        checks++;
        if (rs_data_b !== 32'h0 || rs_busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_init: rs_data=%h busy=%b, want 0/0", rs_data_b, rs_busy_b);
        end
        tick(); rst_n = 1;
        // Write R5 and confirm it landed.
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'hDEADBEEF;
        tick(); idle(); #1;
        checks++;
        if (rs_data_n !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reset_prewrite: rs_data=%h want deadbeef", rs_data_n);
        end
        // Assert reset between edges with a write pending: must read 0 at once, no bypass.
        #2; rst_n = 0;
        wr_en1 = 1; wr_addr1 = 5; wr_data1 = 32'h12345678;
        #1;
        checks++;
        if (rs_data_b !== 32'h0 || rs_data_n !== 32'h0) begin
            errors++; $display("FAIL reset_async: rs_data byp=%h nobyp=%h want 0", rs_data_b, rs_data_n);
        end
        tick(); #2; rst_n = 1; idle(); #1;
        checks++;
        if (rs_data_b !== 32'h0 || rs_data_n !== 32'h0) begin
            errors++; $display("FAIL reset_release: rs_data byp=%h nobyp=%h want 0", rs_data_b, rs_data_n);
        end
        tick();
    endtask

    task automatic test_dual_write();
        wr_en0 = 1; wr_addr0 = 7; wr_data0 = 32'h11;
        wr_en1 = 1; wr_addr1 = 7; wr_data1 = 32'h22;
        tick();
        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'h33;
        wr_en1 = 1; wr_addr1 = 4; wr_data1 = 32'h44;
        tick(); idle();
        rs_addr = 7; rt_addr = 3; #1;
        checks++;
        if (rs_data_n !== 32'h22) begin
            errors++; $display("FAIL dual_collision: R7=%h want 00000022", rs_data_n);
        end
        checks++;
        if (rt_data_n !== 32'h33) begin
            errors++; $display("FAIL dual_port0: R3=%h want 00000033", rt_data_n);
        end
        rt_addr = 4; #1;
        checks++;
        if (rt_data_b !== 32'h44) begin
            errors++; $display("FAIL dual_port1: R4=%h want 00000044", rt_data_b);
        end
        tick();
    endtask

    task automatic test_bypass();
        wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'h1;
        tick(); idle();
        // Both ports hit R9 this cycle; port 1 data must be forwarded.
        wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'h5A5A0000;
        wr_en1 = 1; wr_addr1 = 9; wr_data1 = 32'hA5A5A5A5;
        rs_addr = 9; rt_addr = 9; #1;
        checks++;
        if (rs_data_b !== 32'hA5A5A5A5 || rt_data_b !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_p1: rs=%h rt=%h want a5a5a5a5", rs_data_b, rt_data_b);
        end
        checks++;
        if (rs_data_n !== 32'h1 || rt_data_n !== 32'h1) begin
            errors++; $display("FAIL nobypass_old: rs=%h rt=%h want 00000001", rs_data_n, rt_data_n);
        end
        tick(); idle(); #1;
        checks++;
        if (rs_data_n !== 32'hA5A5A5A5 || rt_data_b !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_after: nobyp=%h byp=%h want a5a5a5a5", rs_data_n, rt_data_b);
        end
        // Port 0 alone is forwarded as well.
        wr_en0 = 1; wr_addr0 = 10; wr_data0 = 32'h77; rs_addr = 10; #1;
        checks++;
        if (rs_data_b !== 32'h77 || rs_data_n !== 32'h0) begin
            errors++; $display("FAIL bypass_p0: byp=%h nobyp=%h want 77/0", rs_data_b, rs_data_n);
        end
        tick(); idle();
    endtask

    task automatic test_zero_reg();
        wr_en0 = 1; wr_addr0 = 0; wr_data0 = 32'hFFFFFFFF;
        rsv_en = 1; rsv_addr = 0; rs_addr = 0; #1;
        checks++;
        if (rs_data_b !== 32'h0 || rs_busy_b !== 1'b0) begin
            errors++; $display("FAIL zero_before: rs=%h busy=%b want 0/0", rs_data_b, rs_busy_b);
        end
        tick(); idle(); #1;
        checks++;
        if (rs_data_b !== 32'h0 || rs_data_n !== 32'h0 || rs_busy_b !== 1'b0) begin
            errors++; $display("FAIL zero_after: rs=%h/%h busy=%b want 0/0/0", rs_data_b, rs_data_n, rs_busy_b);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_addr = 12; rt_addr = 12; #1;
        checks++;
        if (rt_busy_b !== 1'b0) begin
            errors++; $display("FAIL sb_rsv_pre: rt_busy=%b want 0", rt_busy_b);
        end
        tick(); idle(); #1;
        checks++;
        if (rt_busy_b !== 1'b1 || rt_busy_n !== 1'b1) begin
            errors++; $display("FAIL sb_rsv: rt_busy=%b/%b want 1", rt_busy_b, rt_busy_n);
        end
        wr_en0 = 1; wr_addr0 = 12; wr_data0 = 32'hC0; #1;
        checks++;
        if (rt_busy_b !== 1'b1) begin
            errors++; $display("FAIL sb_nobypass: rt_busy=%b want 1", rt_busy_b);
        end
        tick(); idle(); #1;
        checks++;
        if (rt_busy_b !== 1'b0) begin
            errors++; $display("FAIL sb_wr_clear: rt_busy=%b want 0", rt_busy_b);
        end
        rsv_en = 1; rsv_addr = 12; wr_en1 = 1; wr_addr1 = 12; wr_data1 = 32'hC1;
        tick(); idle(); #1;
        checks++;
        if (rt_busy_b !== 1'b1) begin
            errors++; $display("FAIL sb_rsv_wins: rt_busy=%b want 1", rt_busy_b);
        end
        // Flush beats reserve; a write issued in the same cycle still lands.
        rsv_en = 1; rsv_addr = 12; flush = 1;
        wr_en0 = 1; wr_addr0 = 13; wr_data0 = 32'hCAFE;
        tick(); idle(); rs_addr = 13; #1;
        checks++;
        if (rt_busy_b !== 1'b0) begin
            errors++; $display("FAIL sb_flush: rt_busy=%b want 0", rt_busy_b);
        end
        checks++;
        if (rs_data_n !== 32'hCAFE) begin
            errors++; $display("FAIL flush_write: R13=%h want 0000cafe", rs_data_n);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] mdl [32];
        logic [31:0] mbusy;
        logic [31:0] exp_rs, exp_rt;
        int          bad;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        mbusy = 0;
        bad = 0;
        idle(); rst_n = 0; #2; rst_n = 1;
        tick();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            wr_en0 = ($urandom_range(0, 1) == 1); wr_addr0 = 5'($urandom_range(0, 31)); wr_data0 = $urandom;
            wr_en1 = ($urandom_range(0, 1) == 1); wr_addr1 = 5'($urandom_range(0, 31)); wr_data1 = $urandom;
            rsv_en = ($urandom_range(0, 3) == 0); rsv_addr = 5'($urandom_range(0, 31));
            flush  = ($urandom_range(0, 31) == 0);
            // Bias reads toward write addresses so bypass paths are hit often.
            rs_addr = ($urandom_range(0, 1) == 1) ? wr_addr1 : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 1) == 1) ? wr_addr0 : 5'($urandom_range(0, 31));
            #1;
            exp_rs = mdl[rs_addr];
            if (rs_addr != 0 && wr_en1 && wr_addr1 == rs_addr) exp_rs = wr_data1;
            else if (rs_addr != 0 && wr_en0 && wr_addr0 == rs_addr) exp_rs = wr_data0;
            exp_rt = mdl[rt_addr];
            if (rt_addr != 0 && wr_en1 && wr_addr1 == rt_addr) exp_rt = wr_data1;
            else if (rt_addr != 0 && wr_en0 && wr_addr0 == rt_addr) exp_rt = wr_data0;
            checks++;
            if (rs_data_b !== exp_rs || rt_data_b !== exp_rt ||
                rs_data_n !== mdl[rs_addr] || rt_data_n !== mdl[rt_addr] ||
                rs_busy_b !== mbusy[rs_addr] || rt_busy_n !== mbusy[rt_addr]) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random cyc %0d: rs=%h/%h rt=%h/%h busy=%b%b want rs=%h/%h rt=%h/%h busy=%b%b",
                             cyc, rs_data_b, rs_data_n, rt_data_b, rt_data_n, rs_busy_b, rt_busy_n,
                             exp_rs, mdl[rs_addr], exp_rt, mdl[rt_addr], mbusy[rs_addr], mbusy[rt_addr]);
                bad++;
            end
            // Reference update: port 0 then port 1 so port 1 wins; reserve after write-clear; flush last.
            if (wr_en0 && wr_addr0 != 0) begin mdl[wr_addr0] = wr_data0; mbusy[wr_addr0] = 1'b0; end
            if (wr_en1 && wr_addr1 != 0) begin mdl[wr_addr1] = wr_data1; mbusy[wr_addr1] = 1'b0; end
            if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
            if (flush) mbusy = 0;
            tick();
        end
        idle();
    endtask

    initial begin
        rs_addr = 0; rt_addr = 0; rst_n = 0; idle();
        test_reset();
        test_dual_write();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
